exc_arbiter: RTL and testbench
==============================

Name: exc_arbiter

Overview:
- Parametrised exception/interrupt arbiter for the pipelined MIPS core.
- Collects synchronous exception requests from NSRC pipeline channels and masked hardware interrupts, and picks one winner by priority.
- Computes the word-aligned EPC with delay-slot correction, registers ExcCode/EPC/BD for CP0, and tracks handler state (EXL) until eret.
- Sits between the pipeline stage registers and CP0; drives the pipeline flush.

Parameters:
- NSRC, 4, number of exception request channels; channel 0 is the oldest instruction and has the highest priority.
- CODE_W, 5, ExcCode width (Cause[6:2]).
- HWINT, 6, number of hardware interrupt lines.
- CNT_W, 8, width of the saturating taken-event counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- exc_valid  in  NSRC  per-channel exception request.
- exc_code  in  NSRC*CODE_W  per-channel ExcCode; channel i occupies bits [i*CODE_W +: CODE_W].
- exc_pc  in  NSRC*32  per-channel instruction PC; channel i occupies bits [i*32 +: 32].
- exc_bd  in  NSRC  per-channel "instruction is in a delay slot".
- int_pc  in  32  PC of the oldest valid instruction, used for interrupts.
- int_bd  in  1  delay-slot flag for int_pc.
- hw_int  in  HWINT  raw hardware interrupt lines.
- im  in  HWINT  Status.IM.
- ie  in  1  Status.IE.
- eret  in  1  eret retiring this cycle.
- flush  out  1  combinational; pipeline flush this cycle.
- take  out  1  registered one-cycle pulse; an event was accepted.
- code_out  out  CODE_W  registered ExcCode of the last accepted event.
- epc_out  out  32  registered EPC.
- bd_out  out  1  registered Cause.BD.
- ip_out  out  HWINT  registered, synchronised interrupt pending (Cause.IP).
- exl  out  1  handler-active flag.
- eret_done  out  1  registered one-cycle pulse after eret is accepted.
- exc_count  out  CNT_W  saturating count of accepted events.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - take, eret_done, exl, bd_out = 0.
  - code_out, epc_out, ip_out, exc_count = 0.
- Interrupt sync:
  - ip_out <= hw_int on every edge, so interrupt latency from the input is 1 cycle.
  - int_req = |(ip_out & im) & ie & ~exl.
- Exception request:
  - exc_req = |exc_valid & ~exl.
  - win = lowest index i with exc_valid[i]=1.
- Priority: an interrupt beats all exceptions. When int_req is set, code=0 and the interrupt uses int_pc/int_bd. Otherwise the event uses exc_code/exc_pc/exc_bd of channel win.
- EPC rule: base = bd ? pc-4 : pc (32-bit modulo arithmetic; 0x0 with bd wraps to 0xFFFFFFFC). epc = {base[31:2],2'b00}.
- flush = (state==IDLE) & (int_req | exc_req), combinational in the same cycle.
- State machine:
  - IDLE:
    - On flush, at the edge: code_out/epc_out/bd_out are loaded, take<=1, exl<=1, exc_count<=exc_count+1 (saturating at all-ones), and the state goes to HANDLER.
    - An eret arriving in IDLE is ignored.
  - HANDLER:
    - exl=1, so all requests are masked and flush=0.
    - On eret: eret_done<=1, exl<=0, state goes to RETURN.
    - An exception arriving in the same cycle as eret is ignored.
  - RETURN (one cycle):
    - Requests remain masked (exl=0 but flush is forced 0).
    - Then state goes to IDLE, so a pending interrupt can be taken no earlier than 2 cycles after eret.
- take and eret_done are high for exactly one cycle per event.
- code_out, epc_out and bd_out hold their values until the next accepted event.
- Multiple channels valid at once: only the lowest index is recorded; the others are discarded because the flush kills them.
- Reset asserted mid-HANDLER: returns to IDLE with exl=0 and exc_count=0.

Test Plan:
1. Reset, then exc_valid=4'b0100, channel 2 code=5'd12, pc=0x3010, bd=0 -> flush=1 in the same cycle; next cycle take=1, code_out=12, epc_out=0x3010, bd_out=0, exl=1, exc_count=1.
2. exc_valid=4'b0110, ch1 code=4, pc=0x3008, bd=1; ch2 code=10 -> code_out=4, epc_out=0x3004, bd_out=1 (channel 1 wins; delay-slot correction applied).
3. hw_int[2]=1, im=6'b000100, ie=1, exc_valid=4'b0001 with code=8, int_pc=0x4000 -> flush one cycle after hw_int rises; code_out=0, epc_out=0x4000 (interrupt wins).
4. In HANDLER: exc_valid=4'b0001 and eret=1 in the same cycle -> flush=0, eret_done=1 next cycle, exl=0; with an interrupt still pending, take does not rise until 2 cycles after eret.
5. int_pc=0x00000000, int_bd=1, interrupt -> epc_out=0xFFFFFFFC; exc_pc=0x3013, bd=0 -> epc_out=0x3010.
6. With CNT_W=2: accept 5 events (each followed by eret) -> exc_count sequence 1,2,3,3,3. Then assert reset during HANDLER -> exl=0, exc_count=0, take=0 immediately.

Source files
------------

// File: rtl/exc_arbiter.sv
// exc_arbiter -- exception / interrupt arbiter for the pipelined MIPS core.
//
// Collects synchronous exception requests from NSRC pipeline channels plus
// masked hardware interrupts, picks one winner (interrupt first, then the
// oldest channel), computes the word-aligned EPC with delay-slot correction,
// and registers ExcCode/EPC/BD for CP0. Tracks the handler-active flag (EXL)
// from acceptance until eret, with a one-cycle blackout after eret.
//
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   exc_valid/code/pc/bd per-channel exception request (channel 0 = oldest)
//   int_pc, int_bd      PC / delay-slot flag used when an interrupt wins
//   hw_int, im, ie      raw interrupt lines, Status.IM, Status.IE
//   eret                eret retiring this cycle
//   flush               combinational pipeline flush
//   take                one-cycle pulse: event accepted
//   code_out/epc_out/bd_out  registered Cause.ExcCode / EPC / Cause.BD
//   ip_out              synchronised interrupt pending (Cause.IP)
//   exl                 handler active
//   eret_done           one-cycle pulse after eret accepted
//   exc_count           saturating count of accepted events

// Per-channel slice: grant when valid and no older channel is valid, and the
// EPC this channel would produce if it won.
module exc_arb_chan (
    input  logic        valid,
    input  logic        older_valid,
    input  logic [31:0] pc,
    input  logic        bd,
    output logic        grant,
    output logic [31:0] epc
);
    logic [31:0] base;

    // Delay-slot instructions restart at the branch; wraps modulo 2^32.
    assign base  = bd ? (pc - 32'd4) : pc;
    assign epc   = {base[31:2], 2'b00};
    assign grant = valid & ~older_valid;
endmodule

module exc_arbiter #(
    parameter int NSRC   = 4,
    parameter int CODE_W = 5,
    parameter int HWINT  = 6,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NSRC-1:0]          exc_valid,
    input  logic [NSRC*CODE_W-1:0]   exc_code,
    input  logic [NSRC*32-1:0]       exc_pc,
    input  logic [NSRC-1:0]          exc_bd,
    input  logic [31:0]              int_pc,
    input  logic                     int_bd,
    input  logic [HWINT-1:0]         hw_int,
    input  logic [HWINT-1:0]         im,
    input  logic                     ie,
    input  logic                     eret,
    output logic                     flush,
    output logic                     take,
    output logic [CODE_W-1:0]        code_out,
    output logic [31:0]              epc_out,
    output logic                     bd_out,
    output logic [HWINT-1:0]         ip_out,
    output logic                     exl,
    output logic                     eret_done,
    output logic [CNT_W-1:0]         exc_count
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HANDLER = 2'd1,
        S_RETURN  = 2'd2
    } state_t;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [31:0]       epc;
        logic              bd;
    } exc_evt_t;

    state_t state, state_nxt;

    logic [NSRC-1:0]         older_valid;
    logic [NSRC-1:0]         grant;
    logic [NSRC-1:0][31:0]   chan_epc;
    logic [31:0]             int_epc;
    logic                    int_req;
    logic                    exc_req;
    logic                    int_grant_unused;
    exc_evt_t                exc_evt;
    exc_evt_t                win_evt;

    // older_valid[i] = any channel older than i is requesting.
    assign older_valid[0] = 1'b0;
    for (genvar i = 1; i < NSRC; i++) begin : g_older
        assign older_valid[i] = older_valid[i-1] | exc_valid[i-1];
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_chan
        exc_arb_chan u_chan (
            .valid       (exc_valid[i]),
            .older_valid (older_valid[i]),
            .pc          (exc_pc[i*32 +: 32]),
            .bd          (exc_bd[i]),
            .grant       (grant[i]),
            .epc         (chan_epc[i])
        );
    end

    // Same EPC arithmetic reused for the interrupt source.
    exc_arb_chan u_int (
        .valid       (1'b1),
        .older_valid (1'b0),
        .pc          (int_pc),
        .bd          (int_bd),
        .grant       (int_grant_unused),
        .epc         (int_epc)
    );

    // grant is one-hot (or zero), so an OR-mux is sufficient.
    always_comb begin
        exc_evt = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (grant[i]) begin
                exc_evt.code = exc_code[i*CODE_W +: CODE_W];
                exc_evt.epc  = chan_epc[i];
                exc_evt.bd   = exc_bd[i];
            end
        end
    end

    assign int_req = (|(ip_out & im)) & ie & ~exl;
    assign exc_req = (|exc_valid) & ~exl;

    always_comb begin
        win_evt = exc_evt;
        if (int_req) begin
            win_evt.code = '0;
            win_evt.epc  = int_epc;
            win_evt.bd   = int_bd;
        end
    end

    // Next-state and flush. RETURN forces flush low even though exl is 0.
    always_comb begin
        state_nxt = state;
        flush     = 1'b0;
        case (state)
            S_IDLE: begin
                flush = int_req | exc_req;
                if (flush) state_nxt = S_HANDLER;
            end
            S_HANDLER: begin
                if (eret) state_nxt = S_RETURN;
            end
            S_RETURN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            take      <= 1'b0;
            eret_done <= 1'b0;
            exl       <= 1'b0;
            bd_out    <= 1'b0;
            code_out  <= '0;
            epc_out   <= '0;
            ip_out    <= '0;
            exc_count <= '0;
        end else begin
            ip_out    <= hw_int;
            take      <= flush;
            eret_done <= (state == S_HANDLER) & eret;
            exl       <= (state_nxt == S_HANDLER);
            if (flush) begin
                code_out <= win_evt.code;
                epc_out  <= win_evt.epc;
                bd_out   <= win_evt.bd;
                if (exc_count != {CNT_W{1'b1}}) exc_count <= exc_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_exc_arbiter.sv
// Self-checking bench for exc_arbiter: table-driven vectors, directed
// multi-cycle sequences, and randomized stimulus against a behavioural model.
// A second instance with CNT_W=2 shares all inputs to exercise saturation.
module tb_exc_arbiter;
    localparam int NSRC = 4, CODE_W = 5, HWINT = 6;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NSRC-1:0]        exc_valid = '0;
    logic [NSRC*CODE_W-1:0] exc_code = '0;
    logic [NSRC*32-1:0]     exc_pc = '0;
    logic [NSRC-1:0]        exc_bd = '0;
    logic [31:0]            int_pc = '0;
    logic                   int_bd = 1'b0;
    logic [HWINT-1:0]       hw_int = '0, im = '0;
    logic                   ie = 1'b0, eret = 1'b0;

    logic flush, take, bd_out, exl, eret_done;
    logic [CODE_W-1:0] code_out;
    logic [31:0] epc_out;
    logic [HWINT-1:0] ip_out;
    logic [7:0] exc_count;

    logic flush2, take2, bd_out2, exl2, eret_done2;
    logic [CODE_W-1:0] code_out2;
    logic [31:0] epc_out2;
    logic [HWINT-1:0] ip_out2;
    logic [1:0] exc_count2;

    exc_arbiter #(.NSRC(NSRC), .CODE_W(CODE_W), .HWINT(HWINT), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .exc_valid(exc_valid), .exc_code(exc_code),
        .exc_pc(exc_pc), .exc_bd(exc_bd), .int_pc(int_pc), .int_bd(int_bd),
        .hw_int(hw_int), .im(im), .ie(ie), .eret(eret), .flush(flush),
        .take(take), .code_out(code_out), .epc_out(epc_out), .bd_out(bd_out),
        .ip_out(ip_out), .exl(exl), .eret_done(eret_done), .exc_count(exc_count));

    exc_arbiter #(.NSRC(NSRC), .CODE_W(CODE_W), .HWINT(HWINT), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .exc_valid(exc_valid), .exc_code(exc_code),
        .exc_pc(exc_pc), .exc_bd(exc_bd), .int_pc(int_pc), .int_bd(int_bd),
        .hw_int(hw_int), .im(im), .ie(ie), .eret(eret), .flush(flush2),
        .take(take2), .code_out(code_out2), .epc_out(epc_out2), .bd_out(bd_out2),
        .ip_out(ip_out2), .exl(exl2), .eret_done(eret_done2), .exc_count(exc_count2));

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_busy: a handler is running; m_cool: the cycle right after eret, in
    // which nothing may be accepted.
    bit               m_busy, m_cool, m_take, m_eret_done, m_bd;
    logic [HWINT-1:0] m_ip;
    logic [4:0]       m_code;
    logic [31:0]      m_epc;
    int               m_cnt;

    function automatic logic [31:0] epc_of(logic [31:0] pc, logic bd);
        return (pc - (bd ? 32'd4 : 32'd0)) & 32'hFFFF_FFFC;
    endfunction

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_cool = 0; m_take = 0; m_eret_done = 0; m_bd = 0;
        m_ip = '0; m_code = '0; m_epc = '0; m_cnt = 0;
    endtask

    // Inputs must already be driven; checks flush, clocks once, checks state.
    task automatic cycle(string tag);
        bit irq, accept;
        logic [4:0] w_code;
        logic [31:0] w_epc;
        logic w_bd;
        int win;
        #1;
        irq = ((m_ip & im) != 0) && ie && !m_busy;
        accept = !m_busy && !m_cool && (irq || exc_valid != 0);
        win = -1;
        for (int i = NSRC - 1; i >= 0; i--) if (exc_valid[i]) win = i;
        if (irq) begin
            w_code = 0; w_epc = epc_of(int_pc, int_bd); w_bd = int_bd;
        end else begin
            w_code = (win >= 0) ? exc_code[win*CODE_W +: CODE_W] : '0;
            w_epc  = (win >= 0) ? epc_of(exc_pc[win*32 +: 32], exc_bd[win]) : '0;
            w_bd   = (win >= 0) ? exc_bd[win] : 1'b0;
        end
        chk({tag, "_flush"}, flush, accept);
        chk({tag, "_flush2"}, flush2, accept);
        m_take = accept;
        m_eret_done = !accept && m_busy && eret;
        if (accept) begin
            m_code = w_code; m_epc = w_epc; m_bd = w_bd; m_busy = 1; m_cnt++;
        end else if (m_busy && eret) begin
            m_busy = 0; m_cool = 1;
        end else begin
            m_cool = 0;
        end
        m_ip = hw_int;
        @(posedge clk);
        #1;
        chk({tag, "_take"}, take, m_take);
        chk({tag, "_eret_done"}, eret_done, m_eret_done);
        chk({tag, "_exl"}, exl, m_busy);
        chk({tag, "_code"}, code_out, m_code);
        chk({tag, "_epc"}, epc_out, m_epc);
        chk({tag, "_bd"}, bd_out, m_bd);
        chk({tag, "_ip"}, ip_out, m_ip);
        chk({tag, "_cnt"}, exc_count, sat(m_cnt, 255));
        chk({tag, "_cnt2"}, exc_count2, sat(m_cnt, 3));
        chk({tag, "_exl2"}, exl2, m_busy);
    endtask

    task automatic do_reset(string tag);
        reset = 1'b1;
        #1;
        chk({tag, "_rst_take"}, take, 0);
        chk({tag, "_rst_exl"}, exl, 0);
        chk({tag, "_rst_cnt"}, exc_count, 0);
        chk({tag, "_rst_cnt2"}, exc_count2, 0);
        chk({tag, "_rst_epc"}, epc_out, 0);
        chk({tag, "_rst_code"}, code_out, 0);
        chk({tag, "_rst_bd"}, bd_out, 0);
        chk({tag, "_rst_ip"}, ip_out, 0);
        chk({tag, "_rst_eret_done"}, eret_done, 0);
        model_reset();
        #2;
        reset = 1'b0;
    endtask

    // Leave the handler: eret, then the blackout cycle.
    task automatic finish_handler(string tag);
        exc_valid = '0;
        eret = 1'b1;
        cycle({tag, "_eret"});
        eret = 1'b0;
        cycle({tag, "_ret"});
    endtask

    typedef struct {
        logic [NSRC-1:0]        v;
        logic [NSRC*CODE_W-1:0] code;
        logic [NSRC*32-1:0]     pc;
        logic [NSRC-1:0]        bd;
        logic [4:0]             e_code;
        logic [31:0]            e_epc;
        logic                   e_bd;
    } vec_t;

    vec_t vecs[6];

    initial begin
        // ch: {ch3, ch2, ch1, ch0}
        vecs[0] = '{4'b0100, {5'd0, 5'd12, 5'd0, 5'd0},
                    {32'h0, 32'h3010, 32'h0, 32'h0}, 4'b0000, 5'd12, 32'h3010, 1'b0};
        vecs[1] = '{4'b0110, {5'd0, 5'd10, 5'd4, 5'd0},
                    {32'h0, 32'h5000, 32'h3008, 32'h0}, 4'b0010, 5'd4, 32'h3004, 1'b1};
        vecs[2] = '{4'b0001, {5'd0, 5'd0, 5'd0, 5'd9},
                    {32'h0, 32'h0, 32'h0, 32'h3013}, 4'b0000, 5'd9, 32'h3010, 1'b0};
        vecs[3] = '{4'b1111, {5'd3, 5'd2, 5'd1, 5'd13},
                    {32'h40, 32'h30, 32'h20, 32'h10}, 4'b1110, 5'd13, 32'h10, 1'b0};
        vecs[4] = '{4'b1000, {5'd7, 5'd0, 5'd0, 5'd0},
                    {32'h100, 32'h0, 32'h0, 32'h0}, 4'b1000, 5'd7, 32'hFC, 1'b1};
        vecs[5] = '{4'b0001, {5'd0, 5'd0, 5'd0, 5'd11},
                    {32'h0, 32'h0, 32'h0, 32'h0}, 4'b0001, 5'd11, 32'hFFFF_FFFC, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        do_reset("init");
        cycle("idle");

        // Table: single events with interrupts disabled.
        for (int k = 0; k < 6; k++) begin
            exc_valid = vecs[k].v; exc_code = vecs[k].code;
            exc_pc = vecs[k].pc; exc_bd = vecs[k].bd;
            #1;
            chk($sformatf("vec%0d_flush", k), flush, 1);
            cycle($sformatf("vec%0d", k));
            chk($sformatf("vec%0d_code", k), code_out, vecs[k].e_code);
            chk($sformatf("vec%0d_epc", k), epc_out, vecs[k].e_epc);
            chk($sformatf("vec%0d_bdo", k), bd_out, vecs[k].e_bd);
            chk($sformatf("vec%0d_take", k), take, 1);
            chk($sformatf("vec%0d_exl", k), exl, 1);
            finish_handler($sformatf("vec%0d", k));
        end

        // Interrupt: one-cycle sync latency, then beats channel 0.
        hw_int = 6'b000100; im = 6'b000100; ie = 1'b1; int_pc = 32'h4000; int_bd = 1'b0;
        #1;
        chk("irq_noflush_yet", flush, 0);
        cycle("irq_sync");
        exc_valid = 4'b0001; exc_code = {15'd0, 5'd8}; exc_pc = {96'd0, 32'h2000}; exc_bd = '0;
        #1;
        chk("irq_flush", flush, 1);
        cycle("irq_take");
        chk("irq_code", code_out, 0);
        chk("irq_epc", epc_out, 32'h4000);

        // eret with a same-cycle exception; pending interrupt waits 2 cycles.
        eret = 1'b1;
        #1;
        chk("eret_noflush", flush, 0);
        cycle("eret");
        chk("eret_done", eret_done, 1);
        chk("eret_exl", exl, 0);
        chk("eret_take", take, 0);
        eret = 1'b0; exc_valid = '0;
        cycle("eret_p1");
        chk("eret_p1_take", take, 0);
        int_pc = 32'h0; int_bd = 1'b1;
        cycle("eret_p2");
        chk("eret_p2_take", take, 1);
        chk("irq_wrap_epc", epc_out, 32'hFFFF_FFFC);
        hw_int = '0; ie = 1'b0;
        finish_handler("irq_wrap");

        // Counter saturation on the CNT_W=2 instance, then reset in HANDLER.
        do_reset("sat");
        for (int k = 0; k < 5; k++) begin
            exc_valid = 4'b0001; exc_code = {15'd0, 5'd4}; exc_pc = {96'd0, 32'h1000};
            cycle($sformatf("sat%0d", k));
            chk($sformatf("sat%0d_cnt2", k), exc_count2, (k < 3) ? k + 1 : 3);
            chk($sformatf("sat%0d_cnt", k), exc_count, k + 1);
            finish_handler($sformatf("sat%0d", k));
        end
        exc_valid = 4'b0010; exc_pc = {64'd0, 32'h1234, 32'd0};
        cycle("pre_rst");
        chk("pre_rst_take", take, 1);
        exc_valid = '0;
        do_reset("mid_handler");
        cycle("post_rst");

        // Randomized run against the model.
        for (int c = 0; c < 1500; c++) begin
            exc_valid = ($urandom_range(0, 2) == 0) ? NSRC'($urandom) : '0;
            exc_code  = NSRC*CODE_W'($urandom);
            exc_pc    = {$urandom, $urandom, $urandom, $urandom};
            exc_bd    = NSRC'($urandom);
            int_pc    = $urandom;
            int_bd    = 1'($urandom);
            if ($urandom_range(0, 7) == 0) hw_int = HWINT'($urandom);
            if ($urandom_range(0, 15) == 0) im = HWINT'($urandom);
            ie   = ($urandom_range(0, 3) != 0);
            eret = ($urandom_range(0, 2) == 0);
            cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
